// File: rtl/apb_pkg.sv
// Shared APB definitions: bus state encoding, default widths, wait-counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   apb_state_e   IDLE / SETUP / ACCESS, shared by initiator and responder models
//   APB_ADDR_W    default address width
//   APB_DATA_W    default data width
//   wait_cnt_w()  width of a counter that must reach TIMEOUT, never narrower than 1
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // $clog2(1) is 0, which would give a zero-width counter when TIMEOUT is 0.
  function automatic int wait_cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait states and flags the cycle on which the limit is hit.
// Latency: expired is combinational from the current count and enable.
// Backpressure: none; the counter saturates instead of wrapping.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     zero the count (asserted while the transfer is in SETUP)
//   enable    a wait state is occurring this cycle (ACCESS with PREADY low)
//   expired   high during the wait state that is the TIMEOUT-th in a row
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W    = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Count value seen during the last permitted wait state; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturating so that an unbounded wait (TIMEOUT = 0) never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command stream into SETUP/ACCESS transfers.
// Latency: accept -> SETUP next cycle -> ACCESS -> rsp_valid the cycle after PREADY (3 cycles min).
// Backpressure: cmd_ready only in IDLE or on a completing ACCESS; rsp_valid cannot be stalled.
//
// Ports:
//   PCLK, PRESET                  clock and asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_write, cmd_addr, cmd_wdata payload
//   rsp_valid                     one-cycle completion pulse with rsp_rdata and rsp_err
//   busy                          a transfer is in flight
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA                 registered APB request outputs
//   PREADY, PRDATA                APB responder inputs
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  apb_state_e        state;
  apb_state_e        state_next;

  logic              accept;
  logic              load;
  logic              wait_clear;
  logic              wait_en;
  logic              expired;

  logic              psel_next;
  logic              penable_next;
  logic              rsp_valid_next;
  logic              rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_next;

  // A new command can be taken while idle, or on the very edge the current
  // transfer completes, which gives back-to-back transfers with no idle gap.
  assign cmd_ready = (state == IDLE) || ((state == ACCESS) && PREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  assign wait_clear = (state == SETUP);
  assign wait_en    = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    psel_next      = PSEL;
    penable_next   = PENABLE;
    load           = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;

    case (state)
      IDLE: begin
        if (accept) begin
          load         = 1'b1;
          state_next   = SETUP;
          psel_next    = 1'b1;
          penable_next = 1'b0;
        end
      end

      // PREADY is not looked at here; SETUP always lasts exactly one cycle.
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end

      ACCESS: begin
        if (PREADY) begin
          // Completion takes priority over a timeout landing on the same edge.
          rsp_valid_next = 1'b1;
          if (!PWRITE) begin
            rsp_rdata_next = PRDATA;
          end
          if (accept) begin
            load         = 1'b1;
            state_next   = SETUP;
            penable_next = 1'b0;
          end else begin
            state_next   = IDLE;
            psel_next    = 1'b0;
            penable_next = 1'b0;
          end
        end else if (expired) begin
          // cmd_ready is low here, so nothing can be accepted on an abort edge.
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
        end
      end

      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  // Address, data and direction change only on accept and otherwise keep their
  // last value, including through IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      PSEL      <= psel_next;
      PENABLE   <= penable_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
      if (load) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
    end
  end

  a_enable_needs_select : assert property (@(posedge PCLK) disable iff (PRESET)
    PENABLE |-> PSEL);

  a_hold_during_wait : assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && PENABLE && !PREADY) |=> ($stable(PADDR) && $stable(PWDATA) && $stable(PWRITE)));

  // Two completions are always separated by at least a SETUP cycle.
  a_rsp_single_cycle : assert property (@(posedge PCLK) disable iff (PRESET)
    rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: two instances (TIMEOUT=16 and TIMEOUT=0), directed cases with
// literal expectations, then randomized commands and PREADY stalls. A transfer-level
// model (in-flight flag, cycles since accept, wait count) predicts every output each cycle.
module tb_apb_master;

  localparam int TO_A    = 16;
  localparam int TO_B    = 0;
  localparam int N_RAND  = 2500;
  localparam int N_DRAIN = 200;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        PSEL      [2];
  logic        PENABLE   [2];
  logic        PWRITE    [2];
  logic [31:0] PADDR     [2];
  logic [31:0] PWDATA    [2];
  logic        PREADY    [2];
  logic [31:0] PRDATA    [2];

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;
  int rsp_cnt [2];

  // Driver bookkeeping (written only by the stimulus process).
  bit rdy_seen   [2];
  int stall_left [2];
  int sent       [2];
  int base       [2];

  // Model state.
  bit          m_busy  [2];
  int          m_age   [2];
  int          m_stall [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  bit          m_write [2];
  bit          m_rv    [2];
  bit          m_re    [2];
  logic [31:0] m_rd    [2];

  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    apb_master #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT ((g == 0) ? TO_A : TO_B)
    ) u_dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_write (cmd_write[g]),
      .cmd_addr  (cmd_addr[g]),
      .cmd_wdata (cmd_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g]),
      .PSEL      (PSEL[g]),
      .PENABLE   (PENABLE[g]),
      .PWRITE    (PWRITE[g]),
      .PADDR     (PADDR[g]),
      .PWDATA    (PWDATA[g]),
      .PREADY    (PREADY[g]),
      .PRDATA    (PRDATA[g])
    );
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int tmo(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  // The first bus cycle after accept is the setup phase; every later one is access.
  function automatic bit m_in_access(input int k);
    return m_busy[k] && (m_age[k] >= 1);
  endfunction

  function automatic bit m_ready(input int k);
    return !m_busy[k] || (m_in_access(k) && (PREADY[k] === 1'b1));
  endfunction

  function automatic bit m_timeout(input int k);
    return m_in_access(k) && (PREADY[k] !== 1'b1) && (tmo(k) != 0) && (m_stall[k] + 1 == tmo(k));
  endfunction

  function automatic bit m_finish(input int k);
    return m_in_access(k) && ((PREADY[k] === 1'b1) || m_timeout(k));
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    for (int k = 0; k < 2; k++) begin
      if (PRESET) begin
        m_busy[k]  <= 1'b0;
        m_age[k]   <= 0;
        m_stall[k] <= 0;
        m_addr[k]  <= 32'h0;
        m_wdata[k] <= 32'h0;
        m_write[k] <= 1'b0;
        m_rv[k]    <= 1'b0;
        m_re[k]    <= 1'b0;
        m_rd[k]    <= 32'h0;
      end else begin
        m_rv[k] <= m_finish(k);
        m_re[k] <= m_timeout(k);
        m_rd[k] <= (m_in_access(k) && (PREADY[k] === 1'b1) && !m_write[k]) ? PRDATA[k] : 32'h0;
        if ((cmd_valid[k] === 1'b1) && m_ready(k)) begin
          m_busy[k]  <= 1'b1;
          m_age[k]   <= 0;
          m_stall[k] <= 0;
          m_addr[k]  <= cmd_addr[k];
          m_wdata[k] <= cmd_wdata[k];
          m_write[k] <= cmd_write[k];
        end else if (m_finish(k)) begin
          m_busy[k] <= 1'b0;
        end else if (m_busy[k]) begin
          m_age[k] <= m_age[k] + 1;
          if (m_in_access(k)) m_stall[k] <= m_stall[k] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          check("cmd_ready", k, 32'(cmd_ready[k]), 32'(m_ready(k)));
          check("busy",      k, 32'(busy[k]),      32'(m_busy[k]));
          check("PSEL",      k, 32'(PSEL[k]),      32'(m_busy[k]));
          check("PENABLE",   k, 32'(PENABLE[k]),   32'(m_in_access(k)));
          check("PWRITE",    k, 32'(PWRITE[k]),    32'(m_write[k]));
          check("PADDR",     k, PADDR[k],          m_addr[k]);
          check("PWDATA",    k, PWDATA[k],         m_wdata[k]);
          check("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_rv[k]));
          check("rsp_err",   k, 32'(rsp_err[k]),   32'(m_re[k]));
          check("rsp_rdata", k, rsp_rdata[k],      m_rd[k]);
          if (rsp_valid[k] === 1'b1) rsp_cnt[k] = rsp_cnt[k] + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge PCLK);
  endtask

  task automatic drive_step(input int k, input bit issue);
    if ((cmd_valid[k] === 1'b1) && rdy_seen[k]) begin
      cmd_valid[k] = 1'b0;
      sent[k]++;
    end
    if ((cmd_valid[k] !== 1'b1) && issue && ($urandom_range(0, 2) != 0)) begin
      cmd_valid[k] = 1'b1;
      cmd_write[k] = 1'($urandom_range(0, 1));
      cmd_addr[k]  = $urandom;
      cmd_wdata[k] = $urandom;
    end
    if (stall_left[k] > 0) begin
      stall_left[k]--;
      PREADY[k] = 1'b0;
    end else if ($urandom_range(0, 15) == 0) begin
      stall_left[k] = $urandom_range(10, 24);
      PREADY[k] = 1'b0;
    end else begin
      PREADY[k] = ($urandom_range(0, 3) != 0);
    end
    PRDATA[k] = $urandom;
  endtask

  initial begin
    int n_acc;
    bit got;
    int n_rsp;
    logic [3:0] psel_pat;
    logic [3:0] pen_pat;

    PRESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_write[k] = 1'b0;
      cmd_addr[k]  = 32'h0;
      cmd_wdata[k] = 32'h0;
      PREADY[k]    = 1'b1;
      PRDATA[k]    = 32'h0;
      stall_left[k] = 0;
      sent[k]      = 0;
    end
    @(posedge PCLK);
    #1 chk_en = 1'b1;

    // Reset state
    mid();
    check("rst_psel",      0, 32'(PSEL[0]),      32'h0);
    check("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'h0);
    check("rst_paddr",     0, PADDR[0],          32'h0);
    check("rst_cmd_ready", 0, 32'(cmd_ready[0]), 32'h1);
    cyc();
    PRESET = 1'b0;
    cyc();

    // Single write, no wait states
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1;
    cmd_addr[0] = 32'hFFFF_0F0F; cmd_wdata[0] = 32'h0000_00C9; PREADY[0] = 1'b1;
    cyc();
    cmd_valid[0] = 1'b0;
    mid();
    check("t1_setup_psel",    0, 32'(PSEL[0]),    32'h1);
    check("t1_setup_penable", 0, 32'(PENABLE[0]), 32'h0);
    check("t1_paddr",         0, PADDR[0],        32'hFFFF_0F0F);
    check("t1_pwdata",        0, PWDATA[0],       32'h0000_00C9);
    cyc(); mid();
    check("t1_access_penable", 0, 32'(PENABLE[0]), 32'h1);
    cyc(); mid();
    check("t1_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
    check("t1_rsp_err",   0, 32'(rsp_err[0]),   32'h0);
    check("t1_rsp_rdata", 0, rsp_rdata[0],      32'h0);
    check("t1_psel_low",  0, 32'(PSEL[0]),      32'h0);
    cyc(); mid();
    check("t1_rsp_pulse", 0, 32'(rsp_valid[0]), 32'h0);

    // Read with two wait states
    cyc();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0;
    cmd_addr[0] = 32'hF0F0_FFFF; cmd_wdata[0] = 32'h1111_1111; PREADY[0] = 1'b0;
    cyc();
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin
        PREADY[0] = 1'b1;
        PRDATA[0] = 32'h0000_00C9;
      end
      mid();
      check("t2_paddr_stable", 0, PADDR[0],          32'hF0F0_FFFF);
      check("t2_penable",      0, 32'(PENABLE[0]),   32'h1);
    end
    cyc();
    PRDATA[0] = 32'hDEAD_BEEF;
    mid();
    check("t2_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
    check("t2_rsp_rdata", 0, rsp_rdata[0],      32'h0000_00C9);

    // Back-to-back writes with cmd_valid held
    cyc();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1;
    cmd_addr[0] = 32'h1234_5678; cmd_wdata[0] = 32'hABCD_EF01; PREADY[0] = 1'b1;
    cyc();
    cmd_addr[0] = 32'h8765_4321; cmd_wdata[0] = 32'hFEED_FACE;
    psel_pat = 4'h0; pen_pat = 4'h0; n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      if (i == 2) cmd_valid[0] = 1'b0;
      mid();
      if (i < 4) begin
        psel_pat = {psel_pat[2:0], PSEL[0]};
        pen_pat  = {pen_pat[2:0], PENABLE[0]};
      end
      if (i == 2) check("t3_paddr2", 0, PADDR[0], 32'h8765_4321);
      if (rsp_valid[0] === 1'b1) n_rsp++;
    end
    check("t3_psel_pattern",    0, 32'(psel_pat), 32'hF);
    check("t3_penable_pattern", 0, 32'(pen_pat),  32'h5);
    check("t3_rsp_count",       0, n_rsp,         32'd2);
    check("t3_psel_end",        0, 32'(PSEL[0]),  32'h0);

    // Timeout with PREADY stuck low
    cyc();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 32'h0000_7E57; PREADY[0] = 1'b0;
    cyc();
    cmd_valid[0] = 1'b0;
    mid();
    n_acc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(); mid();
      if (PENABLE[0] === 1'b1) n_acc++;
      if (rsp_valid[0] === 1'b1) got = 1'b1;
    end
    check("t4_rsp_seen",     0, 32'(got),         32'h1);
    check("t4_access_count", 0, n_acc,            32'd16);
    check("t4_rsp_err",      0, 32'(rsp_err[0]),  32'h1);
    check("t4_rsp_rdata",    0, rsp_rdata[0],     32'h0);
    check("t4_psel",         0, 32'(PSEL[0]),     32'h0);
    cyc();
    PREADY[0] = 1'b1;

    // Reset during ACCESS
    cyc();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 32'h5555_AAAA; PREADY[0] = 1'b0;
    cyc();
    cmd_valid[0] = 1'b0;
    cyc(); mid();
    check("t5_in_access", 0, 32'(PENABLE[0]), 32'h1);
    #2 PRESET = 1'b1;
    #1;
    check("t5_psel_async",    0, 32'(PSEL[0]),      32'h0);
    check("t5_penable_async", 0, 32'(PENABLE[0]),   32'h0);
    check("t5_rsp_async",     0, 32'(rsp_valid[0]), 32'h0);
    cyc(); cyc();
    PRESET = 1'b0; PREADY[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t5_no_rsp", 0, 32'(rsp_valid[0]), 32'h0);
      cyc();
    end
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 32'hABEF_1234; PRDATA[0] = 32'h600D_F00D;
    cyc();
    cmd_valid[0] = 1'b0;
    cyc(); cyc(); mid();
    check("t5_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
    check("t5_rsp_rdata", 0, rsp_rdata[0],      32'h600D_F00D);
    check("t5_paddr",     0, PADDR[0],          32'hABEF_1234);

    // TIMEOUT=0 instance: 100 wait states, then ready
    cyc();
    cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_addr[1] = 32'h0BAD_CAFE;
    PREADY[1] = 1'b0; PRDATA[1] = 32'h0000_0077;
    cyc();
    cmd_valid[1] = 1'b0;
    mid();
    n_acc = 0; got = 1'b0;
    for (int j = 0; j < 150 && !got; j++) begin
      cyc();
      PREADY[1] = (j >= 100);
      mid();
      if (PENABLE[1] === 1'b1) n_acc++;
      if (rsp_valid[1] === 1'b1) got = 1'b1;
    end
    check("t6_rsp_seen",     1, 32'(got),        32'h1);
    check("t6_access_count", 1, n_acc,           32'd101);
    check("t6_rsp_err",      1, 32'(rsp_err[1]), 32'h0);
    check("t6_rsp_rdata",    1, rsp_rdata[1],    32'h0000_0077);

    // Randomized traffic on both instances
    cyc();
    for (int k = 0; k < 2; k++) begin
      base[k] = rsp_cnt[k];
      sent[k] = 0;
    end
    for (int c = 0; c < N_RAND + N_DRAIN; c++) begin
      mid();
      for (int k = 0; k < 2; k++) rdy_seen[k] = (cmd_ready[k] === 1'b1);
      cyc();
      for (int k = 0; k < 2; k++) drive_step(k, c < N_RAND);
    end
    mid();
    for (int k = 0; k < 2; k++) begin
      check("rand_drained",  k, 32'(cmd_valid[k]),      32'h0);
      check("rand_idle",     k, 32'(busy[k]),           32'h0);
      check("rand_rsp_count", k, rsp_cnt[k] - base[k],  sent[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers. It drives the apb_if responder and its GPIO register block, and is the bus-side driver for the CPU-less subsystem and for system-level tests. It supports back-to-back transfers, PREADY wait states and a bounded wait-state timeout. Completion is reported as a single-cycle response pulse.

Parameters:
ADDR_W, 32, address width (PADDR, cmd_addr)
DATA_W, 32, data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  1 = transfer aborted by timeout
busy  out  1  state != IDLE
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  responder ready
PRDATA  in  DATA_W  responder read data

Behaviour:
- Reset (async, immediate): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter are all 0.
- States: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered; cmd_ready is combinational.
- cmd_ready = (state==IDLE) | (state==ACCESS & PREADY).
- IDLE, on accept: load PADDR, PWDATA (always loaded, even for reads) and PWRITE from cmd_*; go to SETUP. PSEL=1, PENABLE=0.
- SETUP: unconditionally go to ACCESS next cycle (PENABLE=1); clear the wait counter. PREADY is ignored in SETUP.
- ACCESS with PREADY=1: transfer completes at this edge.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata = PRDATA sampled at this edge for reads, 0 for writes.
  - If a command is accepted on the same edge: load the new command, go to SETUP, PSEL stays 1, PENABLE=0.
  - Otherwise: go to IDLE with PSEL=0 and PENABLE=0.
- ACCESS with PREADY=0: hold PSEL, PENABLE, PADDR, PWDATA and PWRITE stable; increment the wait counter.
- Timeout: if TIMEOUT != 0, PREADY=0 and wait counter == TIMEOUT-1, abort at this edge. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, state=IDLE, PSEL=PENABLE=0. No command is accepted on the abort edge.
- PREADY=1 on the would-be timeout edge: normal completion wins.
- rsp_valid is high for exactly one cycle per transfer; no backpressure.
- APB address/data outputs keep their last values in IDLE (not cleared).
- PADDR and PWDATA change only on a command accept.
- Reset mid-transfer: bus drops immediately, no rsp_valid is issued, and the in-flight command is lost.
- Wait counter width is $clog2(TIMEOUT+1), minimum 1; it saturates when TIMEOUT=0.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}
  - APB_ADDR_W=32 and APB_DATA_W=32 defaults
  - the shared responder/initiator state encoding
- One sub-module, apb_wait_timer:
  - inputs: clear, count-enable, TIMEOUT parameter
  - output: expired pulse
- FSM and datapath registers stay in apb_master.

Test Plan:
- Write, cmd_addr=FFFF_0F0F, cmd_wdata=0000_00C9, PREADY=1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_err=0 and rsp_rdata=0, PSEL low at cycle 3.
- Read, cmd_addr=F0F0_FFFF, PREADY low for 2 ACCESS cycles then high with PRDATA=0000_00C9 -> PADDR stable across 3 ACCESS cycles; rsp_rdata=0000_00C9.
- Back-to-back writes with cmd_valid held: (1234_5678, ABCD_EF01) then (8765_4321, FEED_FACE), PREADY=1 -> PSEL high for 4 consecutive cycles, PENABLE pattern 0,1,0,1, two rsp_valid pulses.
- PREADY stuck 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid=1 with rsp_err=1 and rsp_rdata=0; PSEL=0 on the same cycle.
- PRESET asserted mid-ACCESS -> PSEL, PENABLE and rsp_valid go 0 asynchronously; after release, a new read of ABEF_1234 completes normally.
- TIMEOUT=0 with PREADY low for 100 cycles, then high -> normal completion, rsp_err=0.
